// File: rtl/ps2_keyboard_decoder.sv
// PS/2 keyboard receiver: conditions the raw PS/2 lines, deframes 11-bit scan-code frames,
// interprets the F0 break and E0 extended prefixes, and presents the held key as a level
// plus a one-cycle ready pulse per make/break event.
module ps2_keyboard_decoder #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keyboard_data,
  output logic       keyboard_ready,
  output logic       key_release,
  output logic       key_ext,
  output logic       frame_err
);

  localparam int unsigned FiltW    = $clog2(FILTER_LEN + 1);
  localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] CodeBreak = 8'hF0;
  localparam logic [7:0] CodeExt   = 8'hE0;

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StParity,
    StStop,
    StProcess
  } state_e;

  // ---------------------------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------------------------
  logic clk_meta_q, clk_sync_q;
  logic data_meta_q, data_sync_q;

  // Two-flop synchronizers; both lines idle high, so reset them high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic             filt_q, filt_d;
  logic             filt_prev_q;
  logic             fall;

  // Glitch filter: the filtered clock follows the synchronized clock only after FILTER_LEN
  // consecutive samples disagree with it; any agreeing sample restarts the run.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q != filt_q) begin
      if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FiltW'(1);
      end
    end
  end

  // Filter state and edge-detect history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      filt_prev_q <= 1'b1;
    end else begin
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      filt_prev_q <= filt_q;
    end
  end

  assign fall = filt_prev_q & ~filt_q;

  // ---------------------------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic   [7:0]          shift_q;
  logic   [2:0]          bit_cnt_q;
  logic                  parity_ok_q;
  logic   [TimeoutW-1:0] to_cnt_q;
  logic                  brk_q, brk_d;
  logic                  ext_q, ext_d;
  logic                  in_frame;
  logic                  timeout;
  logic                  stop_ok;
  logic                  stop_err;

  logic [7:0] kb_data_q, kb_data_d;
  logic       ready_q, ready_d;
  logic       release_q, release_d;
  logic       ext_out_q, ext_out_d;
  logic       err_q, err_d;

  assign in_frame = (state_q == StData) || (state_q == StParity) || (state_q == StStop);
  // The counter saturates the wait between edges; an edge in the same cycle wins.
  assign timeout  = in_frame && !fall && (to_cnt_q == TimeoutW'(TIMEOUT_CYCLES - 1));
  assign stop_ok  = data_sync_q && parity_ok_q;
  assign stop_err = (state_q == StStop) && fall && !stop_ok;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // A falling edge with data high is not a start bit; ignore it.
        if (fall && !data_sync_q) state_d = StData;
      end
      StData: begin
        if (timeout) state_d = StIdle;
        else if (fall && (bit_cnt_q == 3'd7)) state_d = StParity;
      end
      StParity: begin
        if (timeout) state_d = StIdle;
        else if (fall) state_d = StStop;
      end
      StStop: begin
        if (timeout) state_d = StIdle;
        else if (fall) state_d = stop_ok ? StProcess : StIdle;
      end
      StProcess: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Frame datapath: shift register, bit counter, parity check and inter-edge timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      parity_ok_q <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      if (in_frame && !fall) begin
        to_cnt_q <= to_cnt_q + TimeoutW'(1);
      end else begin
        to_cnt_q <= '0;
      end
      if (fall) begin
        unique case (state_q)
          StIdle: begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
          end
          StData: begin
            // LSB arrives first, so shift in from the top.
            shift_q   <= {data_sync_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
          StParity: parity_ok_q <= ^{shift_q, data_sync_q};
          default: ;
        endcase
      end
    end
  end

  // Output and prefix-flag logic: decides what the processed code does to the key state.
  always_comb begin
    kb_data_d = kb_data_q;
    ready_d   = 1'b0;
    release_d = release_q;
    ext_out_d = ext_out_q;
    err_d     = timeout || stop_err;
    brk_d     = brk_q;
    ext_d     = ext_q;
    if (timeout) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end
    if (state_q == StProcess) begin
      if (shift_q == CodeBreak) begin
        brk_d = 1'b1;
      end else if (shift_q == CodeExt) begin
        ext_d = 1'b1;
      end else begin
        ready_d   = 1'b1;
        release_d = brk_q;
        ext_out_d = ext_q;
        if (!brk_q) begin
          kb_data_d = shift_q;
        end else if (shift_q == kb_data_q) begin
          // Only releasing the held key clears it; other releases leave it alone.
          kb_data_d = 8'h00;
        end
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end
  end

  // Registered outputs and prefix flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kb_data_q <= 8'h00;
      ready_q   <= 1'b0;
      release_q <= 1'b0;
      ext_out_q <= 1'b0;
      err_q     <= 1'b0;
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
    end else begin
      kb_data_q <= kb_data_d;
      ready_q   <= ready_d;
      release_q <= release_d;
      ext_out_q <= ext_out_d;
      err_q     <= err_d;
      brk_q     <= brk_d;
      ext_q     <= ext_d;
    end
  end

  assign keyboard_data  = kb_data_q;
  assign keyboard_ready = ready_q;
  assign key_release    = release_q;
  assign key_ext        = ext_out_q;
  assign frame_err      = err_q;

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Bench for ps2_keyboard_decoder: directed scenarios from the key-event rules followed by a
// randomized frame stream checked against an event-level model of the keyboard state.
module tb_ps2_keyboard_decoder;

  localparam int unsigned FilterLen = 8;
  localparam int unsigned Timeout   = 500;
  localparam int          Half      = 20;   // clk cycles per PS/2 clock half-period
  localparam int          Gap       = 40;   // idle cycles after each frame

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keyboard_data;
  logic       keyboard_ready;
  logic       key_release;
  logic       key_ext;
  logic       frame_err;

  ps2_keyboard_decoder #(
    .FILTER_LEN    (FilterLen),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .keyboard_data (keyboard_data),
    .keyboard_ready(keyboard_ready),
    .key_release   (key_release),
    .key_ext       (key_ext),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Observed events {data, release, ext} and error pulses, sampled mid-cycle.
  logic [9:0] ev_q[$];
  int         err_cnt  = 0;
  int         both_cnt = 0;

  always @(negedge clk) begin
    if (keyboard_ready) ev_q.push_back({keyboard_data, key_release, key_ext});
    if (frame_err) err_cnt++;
    if (keyboard_ready && frame_err) both_cnt++;
  end

  // Reference model: held key plus pending prefixes, and the events they produce.
  logic [7:0] m_key = 8'h00;
  logic       m_brk = 1'b0;
  logic       m_ext = 1'b0;
  logic [9:0] exp_q[$];

  task automatic model_code(input logic [7:0] c);
    if (c == 8'hF0) m_brk = 1'b1;
    else if (c == 8'hE0) m_ext = 1'b1;
    else begin
      if (!m_brk) m_key = c;
      else if (c == m_key) m_key = 8'h00;
      exp_q.push_back({m_key, m_brk, m_ext});
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_key = 8'h00;
    m_brk = 1'b0;
    m_ext = 1'b0;
  endtask

  function automatic logic [9:0] get_ev(input int idx);
    if (idx < ev_q.size()) return ev_q[idx];
    return 10'h3FF;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive the first n bits of a frame, LSB first; data changes while the clock is high.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      wait_cycles(Half);
      ps2_clk = 1'b0;
      wait_cycles(Half);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] code, input logic flip_par, input logic bad_stop);
    logic par;
    par = ~(^code) ^ flip_par;
    send_bits({~bad_stop, par, code, 1'b0}, 11);
    ps2_data = 1'b1;
    wait_cycles(Gap);
    if (!flip_par && !bad_stop) model_code(code);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_cycles(5);
    tests++;
    if ({keyboard_data, keyboard_ready, key_release, key_ext, frame_err} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs got %h want 000",
               {keyboard_data, keyboard_ready, key_release, key_ext, frame_err});
    end
    rst_n = 1'b1;
    wait_cycles(5);
    model_reset();
  endtask

  task automatic test_make();
    ev_q.delete();
    send_frame(8'h1C, 1'b0, 1'b0);
    tests++;
    if (ev_q.size() != 1) begin
      fails++; $display("FAIL make_count got %0d want 1", ev_q.size());
    end
    tests++;
    if (get_ev(0) !== {8'h1C, 2'b00}) begin
      fails++; $display("FAIL make_event got %h want %h", get_ev(0), {8'h1C, 2'b00});
    end
    tests++;
    if (keyboard_data !== 8'h1C) begin
      fails++; $display("FAIL make_level got %h want 1c", keyboard_data);
    end
  endtask

  task automatic test_break();
    ev_q.delete();
    send_frame(8'hF0, 1'b0, 1'b0);
    tests++;
    if (ev_q.size() != 0) begin
      fails++; $display("FAIL break_prefix_count got %0d want 0", ev_q.size());
    end
    send_frame(8'h1C, 1'b0, 1'b0);
    tests++;
    if (ev_q.size() != 1 || get_ev(0) !== {8'h00, 2'b10}) begin
      fails++;
      $display("FAIL break_event got n=%0d ev=%h want n=1 ev=%h", ev_q.size(), get_ev(0),
               {8'h00, 2'b10});
    end
    tests++;
    if (keyboard_data !== 8'h00) begin
      fails++; $display("FAIL break_level got %h want 00", keyboard_data);
    end
  endtask

  task automatic test_break_other();
    ev_q.delete();
    send_frame(8'h23, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1D, 1'b0, 1'b0);
    tests++;
    if (ev_q.size() != 2 || get_ev(1) !== {8'h23, 2'b10}) begin
      fails++;
      $display("FAIL break_other_event got n=%0d ev=%h want n=2 ev=%h", ev_q.size(), get_ev(1),
               {8'h23, 2'b10});
    end
    tests++;
    if (keyboard_data !== 8'h23) begin
      fails++; $display("FAIL break_other_level got %h want 23", keyboard_data);
    end
  endtask

  task automatic test_ext();
    ev_q.delete();
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    tests++;
    if (ev_q.size() != 1 || get_ev(0) !== {8'h75, 2'b01}) begin
      fails++;
      $display("FAIL ext_event got n=%0d ev=%h want n=1 ev=%h", ev_q.size(), get_ev(0),
               {8'h75, 2'b01});
    end
    send_frame(8'h1D, 1'b0, 1'b0);
    tests++;
    if (ev_q.size() != 2 || get_ev(1) !== {8'h1D, 2'b00}) begin
      fails++;
      $display("FAIL ext_cleared got n=%0d ev=%h want n=2 ev=%h", ev_q.size(), get_ev(1),
               {8'h1D, 2'b00});
    end
  endtask

  task automatic test_typematic();
    ev_q.delete();
    send_frame(8'h1D, 1'b0, 1'b0);
    send_frame(8'h1D, 1'b0, 1'b0);
    tests++;
    if (ev_q.size() != 2 || get_ev(1) !== {8'h1D, 2'b00}) begin
      fails++;
      $display("FAIL typematic got n=%0d ev=%h want n=2 ev=%h", ev_q.size(), get_ev(1),
               {8'h1D, 2'b00});
    end
  endtask

  task automatic test_frame_errors();
    int e0;
    ev_q.delete();
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b0);
    tests++;
    if (err_cnt - e0 != 1 || ev_q.size() != 0) begin
      fails++;
      $display("FAIL parity_err got errs=%0d events=%0d want errs=1 events=0", err_cnt - e0,
               ev_q.size());
    end
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1);
    tests++;
    if (err_cnt - e0 != 1 || ev_q.size() != 0) begin
      fails++;
      $display("FAIL stop_err got errs=%0d events=%0d want errs=1 events=0", err_cnt - e0,
               ev_q.size());
    end
    tests++;
    if (keyboard_data !== 8'h1D) begin
      fails++; $display("FAIL err_level got %h want 1d", keyboard_data);
    end
  endtask

  task automatic test_timeout();
    int e0;
    ev_q.delete();
    send_frame(8'hF0, 1'b0, 1'b0);
    e0 = err_cnt;
    send_bits({1'b1, 1'b0, 8'h2B, 1'b0}, 5);   // start + 4 data bits, then the clock stops
    wait_cycles(Timeout + 200);
    m_brk = 1'b0;
    m_ext = 1'b0;
    tests++;
    if (err_cnt - e0 != 1 || ev_q.size() != 0) begin
      fails++;
      $display("FAIL timeout_err got errs=%0d events=%0d want errs=1 events=0", err_cnt - e0,
               ev_q.size());
    end
    send_frame(8'h2B, 1'b0, 1'b0);
    tests++;
    if (ev_q.size() != 1 || get_ev(0) !== {8'h2B, 2'b00}) begin
      fails++;
      $display("FAIL timeout_recover got n=%0d ev=%h want n=1 ev=%h", ev_q.size(), get_ev(0),
               {8'h2B, 2'b00});
    end
  endtask

  task automatic test_reset_mid();
    ev_q.delete();
    send_frame(8'hF0, 1'b0, 1'b0);
    send_bits({1'b1, 1'b0, 8'h55, 1'b0}, 4);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({keyboard_data, keyboard_ready, key_release, key_ext, frame_err} !== 12'h000) begin
      fails++;
      $display("FAIL reset_mid_outputs got %h want 000",
               {keyboard_data, keyboard_ready, key_release, key_ext, frame_err});
    end
    wait_cycles(4);
    rst_n = 1'b1;
    model_reset();
    wait_cycles(4);
    send_frame(8'h1C, 1'b0, 1'b0);
    tests++;
    if (ev_q.size() != 1 || get_ev(0) !== {8'h1C, 2'b00}) begin
      fails++;
      $display("FAIL reset_mid_recover got n=%0d ev=%h want n=1 ev=%h", ev_q.size(), get_ev(0),
               {8'h1C, 2'b00});
    end
  endtask

  task automatic test_random();
    logic [7:0] code;
    logic       bad_par, bad_stop;
    int         e0, sel;
    for (int n = 0; n < 30; n++) begin
      ev_q.delete();
      exp_q.delete();
      e0  = err_cnt;
      sel = $urandom_range(0, 9);
      if (sel < 2) code = 8'hF0;
      else if (sel == 2) code = 8'hE0;
      else if (sel < 5 && m_key != 8'h00) code = m_key;
      else code = 8'($urandom);
      bad_par  = ($urandom_range(0, 9) == 0);
      bad_stop = !bad_par && ($urandom_range(0, 9) == 0);
      send_frame(code, bad_par, bad_stop);
      tests++;
      if (ev_q.size() != exp_q.size() || (exp_q.size() == 1 && get_ev(0) !== exp_q[0])) begin
        fails++;
        $display("FAIL random_event[%0d] code=%h got n=%0d ev=%h want n=%0d ev=%h", n, code,
                 ev_q.size(), get_ev(0), exp_q.size(), (exp_q.size() > 0) ? exp_q[0] : 10'h0);
      end
      tests++;
      if (keyboard_data !== m_key || err_cnt - e0 != int'(bad_par || bad_stop)) begin
        fails++;
        $display("FAIL random_state[%0d] got key=%h errs=%0d want key=%h errs=%0d", n,
                 keyboard_data, err_cnt - e0, m_key, int'(bad_par || bad_stop));
      end
    end
    tests++;
    if (both_cnt != 0) begin
      fails++; $display("FAIL ready_and_err_overlap got %0d want 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_break_other();
    test_ext();
    test_typematic();
    test_frame_errors();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog simulation did not complete within the time limit");
    $fatal(1);
  end

endmodule
